sl_receiver: RTL
================

SL_RECEIVER -- requirements
Module: sl_receiver

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 64, max cycles either line may stay low before a level error.
REQ-002 SHALL have input clk, 1 bit, 16 MHz system clock.
REQ-003 SHALL have input rst_n, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have input sl0, 1 bit, SL line 0, asynchronous to clk.
REQ-005 SHALL have input sl1, 1 bit, SL line 1, asynchronous to clk.
REQ-006 SHALL have input bit_qty, 6 bits, expected data bits per word; 1..32 valid, 0 and >32 treated as 32.
REQ-007 SHALL have input pce, 1 bit, parity check enable.
REQ-008 SHALL have output data_o, 32 bits, last received word, zero-extended above bit_qty.
REQ-009 SHALL have output word_valid, 1 bit, one-cycle pulse on word completion.
REQ-010 SHALL have output parity_err, 1 bit, qualified by word_valid.
REQ-011 SHALL have output length_err, 1 bit, qualified by word_valid.
REQ-012 SHALL have output level_err, 1 bit, one-cycle pulse on line-level fault.
REQ-013 SHALL have output busy, 1 bit, high while a word is in progress.

Function
REQ-014 SHALL pass sl0/sl1 through 2-FF synchronizers; all decoding uses the synchronized pair {s0,s1}.
REQ-015 Line codes: 11 = idle/gap; 10 = bit 1; 01 = bit 0; 00 = stop.
REQ-016 Word format: data bits LSB first, one parity bit, then stop (00), then 11; each bit and the stop are separated by 11.
REQ-017 Parity SHALL be odd: data ones plus parity bit is odd.
REQ-018 FSM states: IDLE, BIT, GAP, STOP, ERR.
REQ-019 IDLE: 10/01 -> BIT, capture bit, count=1, busy=1; 00 -> ERR with level_err; 11 stays.
REQ-020 BIT: same code holds; 11 -> GAP; opposite bit code or 00 -> ERR with level_err.
REQ-021 GAP: 10/01 -> BIT, capture bit, count+1; 00 -> STOP; 11 holds.
REQ-022 Capture: count < bit_qty writes shift position count; count == bit_qty is the parity bit; later bits set an overflow flag only.
REQ-023 STOP: 00 holds; 11 -> IDLE with word_valid pulse the same cycle the FSM registers the 11 sample; 10/01 -> ERR with level_err.
REQ-024 On word_valid, data_o SHALL load the assembled word, and data_o SHALL hold until the next word_valid.
REQ-025 length_err=1 when received bit count (parity included) != bit_qty+1; data_o still loaded.
REQ-026 parity_err=1 when pce=1, length correct, and odd-parity check fails; pce=0 forces 0.
REQ-027 A 7-bit low-time counter clears on any 11 sample; reaching TIMEOUT_CYC in BIT/STOP/IDLE-fault -> ERR, level_err pulse.
REQ-028 ERR: busy=0, no word_valid; exit to IDLE only after 11 is seen for 2 consecutive cycles.
REQ-029 bit_qty and pce SHALL be sampled at first bit of a word and held to word end.
REQ-030 Latency: word_valid 3 clk after raw lines return to 11 after stop.

Reset
REQ-031 rst_n low: FSM=IDLE, synchronizers=1, data_o=0, word_valid/parity_err/length_err/level_err/busy=0, counters=0.
REQ-032 Reset mid-word SHALL discard the partial word with no word_valid and no level_err after release.

Structure
REQ-033 Shared package sl_pkg SHALL hold the line-code constants (IDLE 11, ONE 10, ZERO 01, STOP 00), FSM state encoding, and max word length 32.
REQ-034 The 2-FF synchronizer SHALL be sub-module sl_sync2, instanced once per line; the rest is flat.

Verification
REQ-035 bit_qty=8, pce=1, send 0xA5 with parity bit 1 -> word_valid, data_o=0x000000A5, all errors 0.
REQ-036 Same word with parity bit 0 -> word_valid, parity_err=1, data_o=0x000000A5; with pce=0 -> parity_err=0.
REQ-037 bit_qty=32, send 0xFFFFFFFF with parity bit 1 -> data_o=0xFFFFFFFF, no errors; 7 bits+parity with bit_qty=8 -> length_err=1.
REQ-038 Hold sl0 low 100 cycles mid-word -> level_err pulse at TIMEOUT_CYC, no word_valid, next valid word received correctly.
REQ-039 Both lines go 10 then 01 without gap -> level_err; rst_n pulse mid-word -> outputs at reset values, next word correct.

Source files
------------

// File: rtl/sl_pkg.sv
// rtl/sl_pkg.sv - SL line codes, receiver FSM encoding and word-length helpers.
package sl_pkg;

  localparam logic [1:0] CODE_IDLE = 2'b11;
  localparam logic [1:0] CODE_ONE  = 2'b10;
  localparam logic [1:0] CODE_ZERO = 2'b01;
  localparam logic [1:0] CODE_STOP = 2'b00;

  localparam int MAX_BITS = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_BIT  = 3'd1,
    ST_GAP  = 3'd2,
    ST_STOP = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  // Out-of-range word lengths (0 or above 32) fall back to a full 32-bit word.
  function automatic logic [5:0] eff_qty(input logic [5:0] q);
    if (q == 6'd0 || q > 6'(MAX_BITS)) return 6'(MAX_BITS);
    return q;
  endfunction

endpackage

// File: rtl/sl_sync2.sv
// rtl/sl_sync2.sv - two-flop synchronizer for one SL line; resets to the idle level.
module sl_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sl_receiver.sv
// rtl/sl_receiver.sv - two-wire SL word receiver: decodes bits, parity and stop,
// flags length/parity/level faults.
module sl_receiver
  import sl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sl0,
  input  logic        sl1,
  input  logic [5:0]  bit_qty,
  input  logic        pce,
  output logic [31:0] data_o,
  output logic        word_valid,
  output logic        parity_err,
  output logic        length_err,
  output logic        level_err,
  output logic        busy
);

  logic        s0, s1;
  logic [1:0]  code;
  logic        is_bit;
  state_t      state, state_nx;

  logic [6:0]  low_cnt;
  logic        timeout;
  logic        idle_seen;

  logic [6:0]  count;
  logic [5:0]  qty_q;
  logic        pce_q;
  logic        cur_bit;
  logic        par_bit;
  logic        ovf;
  logic [31:0] shift, shift_nx;

  logic        capture, start, finish, fault;
  logic [6:0]  cap_pos;
  logic [5:0]  cap_qty;
  logic        len_bad;

  sl_sync2 u_sync0 (.clk(clk), .rst_n(rst_n), .d(sl0), .q(s0));
  sl_sync2 u_sync1 (.clk(clk), .rst_n(rst_n), .d(sl1), .q(s1));

  assign code    = {s0, s1};
  assign is_bit  = (code == CODE_ONE) || (code == CODE_ZERO);
  assign timeout = (code != CODE_IDLE) && (low_cnt >= 7'(TIMEOUT_CYC - 1));
  assign busy    = (state == ST_BIT) || (state == ST_GAP) || (state == ST_STOP);

  always_comb begin
    state_nx = state;
    capture  = 1'b0;
    start    = 1'b0;
    finish   = 1'b0;
    fault    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (is_bit) begin
          start    = 1'b1;
          capture  = 1'b1;
          state_nx = ST_BIT;
        end else if (code == CODE_STOP) begin
          fault = 1'b1;
        end
      end
      ST_BIT: begin
        // A bit must hold its own code until the 11 separator arrives.
        if (code == CODE_IDLE) state_nx = ST_GAP;
        else if (code != {cur_bit, ~cur_bit} || timeout) fault = 1'b1;
      end
      ST_GAP: begin
        if (is_bit) begin
          capture  = 1'b1;
          state_nx = ST_BIT;
        end else if (code == CODE_STOP) begin
          state_nx = ST_STOP;
        end
      end
      ST_STOP: begin
        if (code == CODE_IDLE) begin
          finish   = 1'b1;
          state_nx = ST_IDLE;
        end else if (is_bit || timeout) begin
          fault = 1'b1;
        end
      end
      ST_ERR: begin
        if (code == CODE_IDLE && idle_seen) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
    if (fault) state_nx = ST_ERR;
  end

  always_comb begin
    cap_pos  = start ? 7'd0 : count;
    cap_qty  = start ? eff_qty(bit_qty) : qty_q;
    shift_nx = start ? 32'd0 : shift;
    if (capture && cap_pos < {1'b0, cap_qty}) shift_nx[cap_pos[4:0]] = s0;
  end

  assign len_bad = ovf || (count != ({1'b0, qty_q} + 7'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      low_cnt   <= 7'd0;
      idle_seen <= 1'b0;
    end else begin
      if (code == CODE_IDLE)     low_cnt <= 7'd0;
      else if (low_cnt != 7'h7F) low_cnt <= low_cnt + 7'd1;
      idle_seen <= (state == ST_ERR) && (code == CODE_IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= 7'd0;
      qty_q   <= 6'd0;
      pce_q   <= 1'b0;
      cur_bit <= 1'b0;
      par_bit <= 1'b0;
      ovf     <= 1'b0;
      shift   <= 32'd0;
    end else begin
      shift <= shift_nx;
      if (start) begin
        qty_q   <= eff_qty(bit_qty);
        pce_q   <= pce;
        par_bit <= 1'b0;
      end
      if (capture) begin
        cur_bit <= s0;
        if (cap_pos != 7'h7F) count <= cap_pos + 7'd1;
        if (cap_pos == {1'b0, cap_qty}) par_bit <= s0;
        ovf <= (start ? 1'b0 : ovf) | (cap_pos > {1'b0, cap_qty});
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_o     <= 32'd0;
      word_valid <= 1'b0;
      parity_err <= 1'b0;
      length_err <= 1'b0;
      level_err  <= 1'b0;
    end else begin
      word_valid <= finish;
      level_err  <= fault;
      parity_err <= 1'b0;
      length_err <= 1'b0;
      if (finish) begin
        data_o     <= shift;
        length_err <= len_bad;
        // Odd parity: data ones plus the parity bit must be odd.
        parity_err <= pce_q && !len_bad && !(^shift ^ par_bit);
      end
    end
  end

endmodule
